t_counter: RTL and testbench

//   Debounce interval timer used by the button debouncer FSM.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/t_counter.sv | 48 ++++
 tb/tb_t_counter.sv | 110 +++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer and its interval timer.
package debounce_pkg;

  // Default debounce interval: 10 ms at 100 MHz.
  localparam int unsigned DEBOUNCE_COUNT_MAX = 1_000_000;

  // Width needed to hold values 0..count_max inclusive.
  function automatic int unsigned cnt_width(input int unsigned count_max);
    return $clog2(count_max + 1);
  endfunction

  // Debouncer FSM state encoding, shared with the debouncer block.
  typedef enum logic [1:0] {
    DB_WAIT    = 2'd0,
    DB_PRESS   = 2'd1,
    DB_RELEASE = 2'd2
  } db_state_e;

endpackage

// File: rtl/t_counter.sv
// Debounce interval timer: counts cycles while clear is low, raises and
// holds done once COUNT_MAX cycles have elapsed, restarts on clear.
module t_counter
  import debounce_pkg::*;
#(
  parameter int unsigned COUNT_MAX = DEBOUNCE_COUNT_MAX
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clear,
  output logic done
);

  localparam int unsigned    CNT_W   = cnt_width(COUNT_MAX);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(COUNT_MAX);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc_c;

  // Next count value; only used while count is below the top, so it never wraps.
  assign count_inc_c = count + CNT_W'(1);

  // Counter and done flag: reset beats clear, clear beats counting, saturate at top.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      count <= '0;
      done  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      done  <= 1'b0;
    end else if (count < CNT_TOP) begin
      count <= count_inc_c;
      done  <= (count_inc_c == CNT_TOP);
    end
  end

`ifndef SYNTHESIS
  // done is only ever high with the counter parked at the top.
  a_done_at_top : assert property (@(posedge clk) done |-> (count == CNT_TOP));

  // The counter saturates and never exceeds the top.
  a_no_overrun : assert property (@(posedge clk) count <= CNT_TOP);

  // done only drops because reset or clear was sampled on the previous edge.
  a_done_fall : assert property (@(posedge clk) $fell(done) |-> $past(!rst_l || clear));
`endif

endmodule

// File: tb/tb_t_counter.sv
// Scoreboard bench for t_counter with COUNT_MAX=8, plus a COUNT_MAX=1 instance.
module tb_t_counter;

  localparam int unsigned CMAX  = 8;
  localparam int unsigned CMAX1 = 1;

  logic clk;
  logic rst_l;
  logic clear;
  logic done;
  logic done1;

  int n_checks;
  int n_errors;
  int since;

  typedef struct {
    string tag;
    int    done;
    int    count;
    int    done1;
  } exp_t;

  exp_t sb_q[$];

  t_counter #(.COUNT_MAX(CMAX)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .clear (clear),
    .done  (done)
  );

  t_counter #(.COUNT_MAX(CMAX1)) dut1 (
    .clk   (clk),
    .rst_l (rst_l),
    .clear (clear),
    .done  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one edge of stimulus, push the expected outcome, then pop and compare.
  task automatic step(input logic r, input logic c, input string tag);
    exp_t e;
    rst_l = r;
    clear = c;
    if (!r || c) since = 0;
    else         since++;
    e.tag   = tag;
    e.done  = (since >= int'(CMAX))  ? 1 : 0;
    e.count = (since >  int'(CMAX))  ? int'(CMAX) : since;
    e.done1 = (since >= int'(CMAX1)) ? 1 : 0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    chk("sb_depth", sb_q.size(), 1);
    e = sb_q.pop_front();
    chk($sformatf("%s_done", e.tag),  int'(done),       e.done);
    chk($sformatf("%s_count", e.tag), int'(dut.count),  e.count);
    chk($sformatf("%s_done1", e.tag), int'(done1),      e.done1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    since    = 0;
    rst_l    = 1'b0;
    clear    = 1'b0;

    // Reset for two edges with clear low.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, $sformatf("rst%0d", i));

    // Release: done rises on edge 8, then saturates through edge 20.
    for (int i = 1; i <= 20; i++) step(1'b1, 1'b0, $sformatf("run_e%0d", i));

    // Restart, count to 5, single-cycle clear, then a full interval again.
    step(1'b1, 1'b1, "clr_start");
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, $sformatf("pre_e%0d", i));
    step(1'b1, 1'b1, "clr_mid");
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, $sformatf("post_e%0d", i));

    // Clear while done is high: done drops next cycle, re-asserts after 8 edges.
    step(1'b1, 1'b1, "clr_done");
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, $sformatf("redo_e%0d", i));

    // Reset mid-count with clear low, then with clear high.
    step(1'b1, 1'b1, "prio_clr");
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, $sformatf("prio_a%0d", i));
    step(1'b0, 1'b0, "rst_noclr");
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, $sformatf("prio_b%0d", i));
    step(1'b0, 1'b1, "rst_clr");
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, $sformatf("tail_e%0d", i));

    chk("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
